// File: rtl/f1_lights_monitor.sv
// Start-light bar monitor: validates the thermometer ramp, detects lights-out,
// and measures the driver's reaction time in saturating millisecond ticks.
module f1_lights_monitor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] lights,
   input  logic             btn,
   input  logic             tick,
   output logic [CNT_W-1:0] reaction_ms,
   output logic             result_valid,
   output logic             jump_start,
   output logic             seq_error,
   output logic             busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RAMP   = 3'd1,
      ST_ALL_ON = 3'd2,
      ST_TIMING = 3'd3,
      ST_DONE   = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   localparam logic [WIDTH-1:0] LIGHTS_OFF = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] LIGHTS_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] LIGHTS_ALL = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   // Increment that sticks at the top instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = CNT_MAX;
      end else begin
         sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   state_t           state_r;
   logic [WIDTH-1:0] lights_q_r;
   logic             btn_q_r;
   logic [CNT_W-1:0] cnt_r;

   logic             press_s;
   logic             chg_s;
   logic [WIDTH-1:0] nxt_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [CNT_W-1:0] capture_s;

   // Edge detection, expected next ramp step, and the tick-inclusive capture value.
   always_comb begin
      press_s   = btn & ~btn_q_r;
      chg_s     = (lights != lights_q_r);
      nxt_s     = {lights_q_r[WIDTH-2:0], 1'b1};
      cnt_inc_s = sat_inc(cnt_r);
      if (tick) begin
         capture_s = cnt_inc_s;
      end else begin
         capture_s = cnt_r;
      end
   end

   // Sequence FSM with all outputs registered; a press always beats a light change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         lights_q_r   <= LIGHTS_OFF;
         btn_q_r      <= 1'b0;
         cnt_r        <= CNT_ZERO;
         reaction_ms  <= CNT_ZERO;
         result_valid <= 1'b0;
         jump_start   <= 1'b0;
         seq_error    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         lights_q_r   <= lights;
         btn_q_r      <= btn;
         result_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if ((lights == LIGHTS_ONE) && chg_s) begin
                  state_r <= ST_RAMP;
                  busy    <= 1'b1;
               end else if (lights != LIGHTS_OFF) begin
                  state_r   <= ST_FAULT;
                  seq_error <= 1'b1;
               end
            end
            ST_RAMP: begin
               if (press_s) begin
                  state_r    <= ST_DONE;
                  jump_start <= 1'b1;
                  busy       <= 1'b0;
               end else if (chg_s) begin
                  if (lights == nxt_s) begin
                     if (lights == LIGHTS_ALL) begin
                        state_r <= ST_ALL_ON;
                     end
                  end else begin
                     state_r   <= ST_FAULT;
                     seq_error <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
            end
            ST_ALL_ON: begin
               if (press_s) begin
                  state_r    <= ST_DONE;
                  jump_start <= 1'b1;
                  busy       <= 1'b0;
               end else if (chg_s) begin
                  if (lights == LIGHTS_OFF) begin
                     state_r <= ST_TIMING;
                     cnt_r   <= CNT_ZERO;
                  end else begin
                     state_r   <= ST_FAULT;
                     seq_error <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
            end
            ST_TIMING: begin
               if (press_s) begin
                  state_r      <= ST_DONE;
                  reaction_ms  <= capture_s;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
               end else if (lights != LIGHTS_OFF) begin
                  state_r   <= ST_FAULT;
                  seq_error <= 1'b1;
                  busy      <= 1'b0;
               end else if (tick) begin
                  cnt_r <= cnt_inc_s;
               end
            end
            ST_DONE: begin
               if ((lights == LIGHTS_ONE) && chg_s) begin
                  state_r    <= ST_RAMP;
                  jump_start <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            ST_FAULT: begin
               if (lights == LIGHTS_OFF) begin
                  state_r    <= ST_IDLE;
                  seq_error  <= 1'b0;
                  jump_start <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               seq_error  <= 1'b0;
               jump_start <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
